// File: rtl/mdu_iter_e.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply
// and restoring divide, one radix-2 step per falling clock edge.
module mdu_iter_e #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             StartE,
  input  logic [2:0]       Fun3E,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE,
  output logic [1:0]       dbg_state
);

  // Handshake: an op is accepted at the first falling edge in IDLE with StartE
  // high. BusyE holds the instruction in E until DONE. DoneE is high for exactly
  // one cycle with ResultE, and the instruction leaves E at that edge.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic               sign_a;
  logic               sign_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;

  logic               is_div;
  logic               a_signed;
  logic               b_signed;
  logic               sa_in;
  logic               sb_in;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   fast_res;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_final;

  // MULHSU treats only rs1 as signed; MUL needs no sign handling for the low half.
  assign is_div   = Fun3E[2];
  assign a_signed = (Fun3E == 3'b001) || (Fun3E == 3'b010) || (is_div && !Fun3E[0]);
  assign b_signed = (Fun3E == 3'b001) || (is_div && !Fun3E[0]);
  assign sa_in    = a_signed && SrcAE[WIDTH-1];
  assign sb_in    = b_signed && SrcBE[WIDTH-1];
  assign abs_a    = sa_in ? -SrcAE : SrcAE;
  assign abs_b    = sb_in ? -SrcBE : SrcBE;
  assign div_zero = is_div && (SrcBE == '0);
  assign div_ovf  = is_div && !Fun3E[0] && (SrcAE == MIN_VAL) && (SrcBE == '1);

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = Fun3E[1] ? SrcAE : '1;
    end else if (div_ovf) begin
      fast_res = Fun3E[1] ? '0 : MIN_VAL;
    end
  end

  // Multiply: acc = {partial product, multiplier}, add then shift right.
  // Divide:   acc = {partial remainder, dividend/quotient}, shift left then trial-subtract.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign diff    = rem_sh - {1'b0, opb};

  always_comb begin
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (op[2]) begin
      if (diff[WIDTH]) begin
        acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Sign correction is applied to the value produced by the final step.
  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc_step : acc_step;
    quo  = (sign_a ^ sign_b) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem  = sign_a ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    if (op[2]) begin
      res_final = op[1] ? rem : quo;
    end else if (op[1:0] == 2'b00) begin
      res_final = prod[WIDTH-1:0];
    end else begin
      res_final = prod[2*WIDTH-1:WIDTH];
    end
  end

  assign BusyE     = ((state == IDLE) && StartE) || (state == CALC);
  assign dbg_state = state;

  always_ff @(negedge clk) begin
    if (!reset || clear) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      acc     <= '0;
      opb     <= '0;
      DoneE   <= 1'b0;
      ResultE <= '0;
    end else begin
      case (state)
        IDLE: begin
          DoneE <= 1'b0;
          if (StartE) begin
            op     <= Fun3E;
            sign_a <= sa_in;
            sign_b <= sb_in;
            cnt    <= '0;
            if (div_zero || div_ovf) begin
              ResultE <= fast_res;
              DoneE   <= 1'b1;
              state   <= DONE;
            end else begin
              acc   <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
              opb   <= is_div ? abs_b : abs_a;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            ResultE <= res_final;
            DoneE   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          DoneE <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DoneE <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter_e.sv
// Bench for mdu_iter_e: directed vector table, multi-cycle corner sequences and
// random ops checked against an arithmetic reference model.
module tb_mdu_iter_e;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         StartE;
  logic [2:0]   Fun3E;
  logic [W-1:0] SrcAE;
  logic [W-1:0] SrcBE;
  logic         BusyE;
  logic         DoneE;
  logic [W-1:0] ResultE;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  bit           hold_next;
  logic [2:0]   nxt_f3;
  logic [W-1:0] nxt_a;
  logic [W-1:0] nxt_b;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;
  vec_t vecs[14];

  mdu_iter_e #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .StartE    (StartE),
    .Fun3E     (Fun3E),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .BusyE     (BusyE),
    .DoneE     (DoneE),
    .ResultE   (ResultE),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: 64-bit arithmetic straight from the RV32M definitions.
  function automatic logic [W-1:0] ref_mdu(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [63:0] as;
    logic signed [63:0] bs;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic [63:0]        p;
    logic signed [63:0] q;
    as = {{32{a[31]}}, a};
    bs = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = 64'b0;
    q  = 64'sd0;
    case (f3)
      3'b000: begin p = as * bs; return p[31:0]; end
      3'b001: begin p = as * bs; return p[63:32]; end
      3'b010: begin p = as * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        q = as / bs; return q[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        q = as % bs; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return MINV;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // driver: issue one op, hold StartE while stalled, scramble operands once accepted
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int negs;
    int busy;
    bit got;
    logic [W-1:0] want;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    StartE = 1'b1; Fun3E = f3; SrcAE = a; SrcBE = b;
    #1;
    busy = BusyE ? 1 : 0;
    negs = 0;
    got  = 1'b0;
    while (!got && negs < 100) begin
      @(negedge clk); negs++;
      #1;
      SrcAE = $urandom; SrcBE = $urandom;
      @(posedge clk); #1;
      if (BusyE) busy++;
      if (DoneE) got = 1'b1;
    end
    check({nm, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      want = exp_q.pop_front();
      check({nm, " result"}, ResultE, want);
      check({nm, " done_negedge"}, 32'(negs), 32'(lat));
      check({nm, " busy_cycles"}, 32'(busy), 32'(lat));
    end else begin
      exp_q.delete();
    end
    if (hold_next) begin
      Fun3E = nxt_f3; SrcAE = nxt_a; SrcBE = nxt_b;
    end else begin
      StartE = 1'b0;
    end
    @(negedge clk); #1;
    check({nm, " done_one_cycle"}, 32'(DoneE), 32'd0);
    check({nm, " busy_after"}, 32'(BusyE), 32'(hold_next));
    check({nm, " result_held"}, ResultE, exp);
  endtask

  task automatic abort_test(input bit use_reset);
    int seen;
    string nm;
    nm = use_reset ? "reset_abort" : "clear_abort";
    run_op({nm, "_pre"}, 3'b101, 32'd100, 32'd7, 32'd14, W + 1);
    @(posedge clk); #1;
    StartE = 1'b1; Fun3E = 3'b000; SrcAE = 32'h0001_2345; SrcBE = 32'h0000_6789;
    repeat (11) @(negedge clk);
    #1;
    if (use_reset) reset = 1'b0; else clear = 1'b1;
    @(negedge clk); #1;
    reset = 1'b1; clear = 1'b0; StartE = 1'b0;
    #1;
    check({nm, " busy"}, 32'(BusyE), 32'd0);
    check({nm, " done"}, 32'(DoneE), 32'd0);
    check({nm, " result"}, ResultE, 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (DoneE || BusyE) seen++;
    end
    check({nm, " quiet_after"}, 32'(seen), 32'd0);
    run_op({nm, "_post"}, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W + 1);
  endtask

  initial begin
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset = 1'b0; clear = 1'b0; StartE = 1'b0; Fun3E = 3'b0;
    SrcAE = '0; SrcBE = '0; hold_next = 1'b0;
    nxt_f3 = 3'b0; nxt_a = '0; nxt_b = '0;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    vecs[12] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
    vecs[13] = '{3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 33};

    repeat (3) @(negedge clk);
    #1;
    check("reset busy", 32'(BusyE), 32'd0);
    check("reset done", 32'(DoneE), 32'd0);
    check("reset result", ResultE, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // StartE stays high through DONE; the second op must start only from IDLE.
    hold_next = 1'b1;
    nxt_f3 = 3'b100; nxt_a = 32'hFFFF_FF9C; nxt_b = 32'd7;
    run_op("b2b_first", 3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, W + 1);
    hold_next = 1'b0;
    run_op("b2b_second", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, W + 1);

    abort_test(1'b0);
    abort_test(1'b1);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rnd_op();
      b  = rnd_op();
      run_op($sformatf("rand%0d_f%0d_%h_%h", i, f3, a, b), f3, a, b,
             ref_mdu(f3, a, b), ref_lat(f3, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
